// File: rtl/reg_file_scoreboard.sv
// Register file with a busy-bit scoreboard for in-order issue.
// Holds x1..x31, registered 2-read operand path with write-back bypass,
// RAW/WAW stall generation, pending-write count and a sticky write-back error.
module reg_file_scoreboard #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            rd_req,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            iss_valid,
  input  logic            iss_rd_en,
  input  logic [4:0]      iss_rd,
  output logic            iss_stall,
  output logic [5:0]      pend_cnt,
  output logic            wb_err
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic wb_act, iss_set, inc, dec;
  logic clr_rs1, clr_rs2, clr_rd;

  // Write-back to x0 is a no-op everywhere, so qualify it once here.
  assign wb_act  = wb_en && (wb_rd != 5'd0);
  assign clr_rs1 = wb_act && (wb_rd == rs1_addr);
  assign clr_rs2 = wb_act && (wb_rd == rs2_addr);
  assign clr_rd  = wb_act && (wb_rd == iss_rd);

  // Hazard check; a same-cycle write-back to the register releases it.
  always_comb begin
    iss_stall = iss_valid &&
                ((busy_q[rs1_addr] && !clr_rs1) ||
                 (busy_q[rs2_addr] && !clr_rs2) ||
                 (iss_rd_en && busy_q[iss_rd] && !clr_rd));
  end

  assign iss_set = iss_valid && !iss_stall && iss_rd_en && (iss_rd != 5'd0);

  // Next busy map, count and error; set beats clear on the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_act)  busy_d[wb_rd]  = 1'b0;
    if (iss_set) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    // Count only real 0->1 and 1->0 transitions so it tracks popcount(busy).
    inc   = iss_set && !busy_q[iss_rd];
    dec   = wb_act && busy_q[wb_rd] && !(iss_set && (iss_rd == wb_rd));
    cnt_d = cnt_q + {5'd0, inc} - {5'd0, dec};
    err_d = err_q || (wb_act && !busy_q[wb_rd]);
  end

  // Operand read with bypass of the write-back landing this same edge.
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (rd_req) begin
      if (rs1_addr == 5'd0) rs1_d = '0;
      else if (clr_rs1)     rs1_d = wb_data;
      else                  rs1_d = regs_q[rs1_addr];
      if (rs2_addr == 5'd0) rs2_d = '0;
      else if (clr_rs2)     rs2_d = wb_data;
      else                  rs2_d = regs_q[rs2_addr];
    end
  end

  // Register storage; x0 is never written and reads are forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_act) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Scoreboard and output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign pend_cnt = cnt_q;
  assign wb_err   = err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard with hand-computed expectations.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rd_req;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        iss_valid, iss_rd_en;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic [5:0]  pend_cnt;
  logic        wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_scoreboard #(.NREGS(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_req(rd_req), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .iss_valid(iss_valid), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
    .iss_stall(iss_stall), .pend_cnt(pend_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_en = 0; wb_rd = 0; wb_data = 0;
    rd_req = 0; rs1_addr = 0; rs2_addr = 0;
    iss_valid = 0; iss_rd_en = 0; iss_rd = 0;
  endtask

  // Advance one edge and settle; inputs return to idle afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1; iss_rd_en = 1; iss_rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1; wb_rd = rd; wb_data = d;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rd_req = 1; rs1_addr = a1; rs2_addr = a2;
  endtask

  initial begin
    idle();
    rst = 1;
    // Busy-free during reset even with a request presented.
    iss_valid = 1; iss_rd_en = 1; iss_rd = 3; rs1_addr = 3; rs2_addr = 4;
    wb_en = 1; wb_rd = 3; wb_data = 32'hAAAA_5555; rd_req = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rs1", rs1_data, 0);
    chk("rst_rs2", rs2_data, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_stall", iss_stall, 0);
    idle();
    rst = 0;
    #1;
    chk("post_rst_stall", iss_stall, 0);

    // Write then read x5 (issue first so the write-back is legitimate).
    issue(5); tick();
    chk("iss5_pend", pend_cnt, 1);
    wb(5, 32'hDEADBEEF); tick();
    chk("wb5_pend", pend_cnt, 0);
    chk("wb5_err", wb_err, 0);
    rd(5, 0); tick();
    chk("rd5_rs1", rs1_data, 32'hDEADBEEF);
    chk("rd5_rs2", rs2_data, 0);
    // rd_req low: outputs hold.
    rs1_addr = 7; tick();
    chk("hold_rs1", rs1_data, 32'hDEADBEEF);

    // Bypass and x0.
    issue(7); tick();
    wb(7, 32'h1234); rd(7, 0); tick();
    chk("byp_rs1", rs1_data, 32'h1234);
    chk("byp_rs2", rs2_data, 0);
    chk("byp_pend", pend_cnt, 0);
    wb(0, 32'hFFFF_FFFF); tick();
    chk("x0_pend", pend_cnt, 0);
    chk("x0_err", wb_err, 0);
    rd(0, 5); tick();
    chk("x0_rs1", rs1_data, 0);
    chk("x0_rs2", rs2_data, 32'hDEADBEEF);

    // RAW / WAW.
    issue(3); tick();
    chk("iss3_pend", pend_cnt, 1);
    iss_valid = 1; rs1_addr = 3; #1;
    chk("raw_stall", iss_stall, 1);
    tick();
    iss_valid = 1; rs2_addr = 3; #1;
    chk("raw2_stall", iss_stall, 1);
    idle();
    issue(3); #1;
    chk("waw_stall", iss_stall, 1);
    tick();
    chk("waw_pend", pend_cnt, 1);
    iss_valid = 1; rs1_addr = 3; wb(3, 32'h33); #1;
    chk("raw_rel_stall", iss_stall, 0);
    tick();
    chk("raw_rel_pend", pend_cnt, 0);

    // Simultaneous set and clear.
    issue(4); tick();
    chk("iss4_pend", pend_cnt, 1);
    issue(4); wb(4, 32'h44); #1;
    chk("sc_same_stall", iss_stall, 0);
    tick();
    chk("sc_same_pend", pend_cnt, 1);
    iss_valid = 1; rs1_addr = 4; #1;
    chk("busy4_kept", iss_stall, 1);
    idle();
    issue(6); wb(4, 32'h45); #1;
    chk("sc_diff_stall", iss_stall, 0);
    tick();
    chk("sc_diff_pend", pend_cnt, 1);
    iss_valid = 1; rs1_addr = 4; #1;
    chk("busy4_clr", iss_stall, 0);
    rs1_addr = 6; #1;
    chk("busy6_set", iss_stall, 1);
    idle();
    chk("no_err_yet", wb_err, 0);

    // Error on write-back to a non-busy register; write still lands.
    wb(9, 32'h99); tick();
    chk("err_set", wb_err, 1);
    chk("err_pend", pend_cnt, 1);
    rd(9, 4); tick();
    chk("err_rs1", rs1_data, 32'h99);
    chk("err_rs2", rs2_data, 32'h45);
    tick();
    chk("err_sticky", wb_err, 1);
    issue(10); tick();
    issue(11); tick();
    chk("pend3", pend_cnt, 3);

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1;
    #1;
    chk("arst_rs1", rs1_data, 0);
    chk("arst_rs2", rs2_data, 0);
    chk("arst_pend", pend_cnt, 0);
    chk("arst_err", wb_err, 0);
    iss_valid = 1; rs1_addr = 6; issue(10); wb(9, 32'h77); rd(9, 0);
    #1;
    chk("arst_stall", iss_stall, 0);
    tick();
    chk("arst_hold_rs1", rs1_data, 0);
    chk("arst_hold_pend", pend_cnt, 0);
    rst = 0;
    rd(9, 5); tick();
    chk("rel_rs1", rs1_data, 0);
    chk("rel_rs2", rs2_data, 0);
    chk("rel_err", wb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
